// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, horizontal/vertical counters and
// registered sync, visible-area and line/frame start strobes aligned to the counters.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FP      = 56,
  parameter int unsigned H_SYNC    = 120,
  parameter int unsigned H_BP      = 64,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FP      = 37,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BP      = 23,
  parameter logic        H_POL     = 1'b1,
  parameter logic        V_POL     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pixel_tick,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end
  if (H_TOTAL > 2048) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL-1 does not fit in 11 bits");
  end
  if (V_TOTAL > 1024) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL-1 does not fit in 10 bits");
  end

  // Comparison constants are one bit wider so a sync end equal to the total still fits.
  localparam logic [3:0]  DivLast = 4'(CLK_DIV - 1);
  localparam logic [11:0] HLast   = 12'(H_TOTAL - 1);
  localparam logic [11:0] HVis    = 12'(H_VISIBLE);
  localparam logic [11:0] HsStart = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] HsEnd   = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VLast   = 11'(V_TOTAL - 1);
  localparam logic [10:0] VVis    = 11'(V_VISIBLE);
  localparam logic [10:0] VsStart = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VsEnd   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [3:0]  div_q, div_d;
  logic        tick_q;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        run_q, run_d;
  logic        hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
  logic        line_wrap, frame_wrap, hs_act, vs_act, visible;
  logic [11:0] x_ext;
  logic [10:0] y_ext;

  always_comb begin
    div_d      = (div_q == DivLast) ? 4'd0 : div_q + 4'd1;
    run_d      = run_q | ~rst;
    x_d        = x_q;
    y_d        = y_q;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;
    if (tick_q) begin
      if ({1'b0, x_q} == HLast) begin
        x_d       = '0;
        line_wrap = 1'b1;
        if ({1'b0, y_q} == VLast) begin
          y_d        = '0;
          frame_wrap = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 11'd1;
      end
    end
    // Decode from next-state counts so the registered outputs line up with the counters.
    x_ext   = {1'b0, x_d};
    y_ext   = {1'b0, y_d};
    hs_act  = (x_ext >= HsStart) && (x_ext < HsEnd);
    vs_act  = (y_ext >= VsStart) && (y_ext < VsEnd);
    visible = run_d && (x_ext < HVis) && (y_ext < VVis);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      tick_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      run_q         <= 1'b0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      tick_q        <= (div_q == DivLast);
      x_q           <= x_d;
      y_q           <= y_d;
      run_q         <= run_d;
      hsync_q       <= hs_act ? H_POL : ~H_POL;
      vsync_q       <= vs_act ? V_POL : ~V_POL;
      video_on_q    <= visible;
      line_start_q  <= line_wrap;
      frame_start_q <= frame_wrap;
    end
  end

  assign pixel_tick  = tick_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 timing on dut_a, plus a shrunken CLK_DIV=1,
// active-low sync instance on dut_b so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  logic        a_tick, a_hs, a_vs, a_vo, a_ls, a_fs;
  logic [10:0] a_x;
  logic [9:0]  a_y;
  logic        b_tick, b_hs, b_vs, b_vo, b_ls, b_fs;
  logic [10:0] b_x;
  logic [9:0]  b_y;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .pixel_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .line_start(a_ls), .frame_start(a_fs)
  );

  // H: 16+2+3+2 = 23, V: 10+2+2+3 = 17 -> 391 clocks per frame.
  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .H_POL(1'b0), .V_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pixel_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .line_start(b_ls), .frame_start(b_fs)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Step to the next negedge until dut_a reaches (x,y); returns 1 if found in budget.
  task automatic wait_a(input int x, input int y, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (a_x == 11'(x) && a_y == 10'(y)) found = 1'b1;
    end
  endtask

  initial begin
    int hs_clks, hs_min, hs_max, vo_fall, ls_cnt, ls_x, ls_y, ls_c, afs_cnt;
    int b_tick_lo, b_fs_cnt, b_fs_c1, b_fs_c2, b_fs_bad, b_vs_min, b_vs_max;
    int b_hs_min, b_hs_max, b_hs_clks0, b_vo_bad, spur;
    bit found;
    hs_clks = 0; hs_min = 9999; hs_max = -1; vo_fall = -1;
    ls_cnt = 0; ls_x = -1; ls_y = -1; ls_c = -1; afs_cnt = 0;
    b_tick_lo = 0; b_fs_cnt = 0; b_fs_c1 = -1; b_fs_c2 = -1; b_fs_bad = 0;
    b_vs_min = 9999; b_vs_max = -1; b_hs_min = 9999; b_hs_max = -1;
    b_hs_clks0 = 0; b_vo_bad = 0; spur = 0;

    repeat (3) @(negedge clk);
    check("rst_a_x", 32'(a_x), 0);
    check("rst_a_y", 32'(a_y), 0);
    check("rst_a_hsync", 32'(a_hs), 0);
    check("rst_a_vsync", 32'(a_vs), 0);
    check("rst_a_video_on", 32'(a_vo), 0);
    check("rst_a_tick", 32'(a_tick), 0);
    check("rst_a_strobes", 32'({a_ls, a_fs}), 0);
    check("rst_b_hsync_idle", 32'(b_hs), 1);
    check("rst_b_vsync_idle", 32'(b_vs), 1);

    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int c = 1; c <= 2100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("rel_video_on", 32'(a_vo), 1);
        check("rel_c1_tick", 32'(a_tick), 0);
        check("rel_c1_x", 32'(a_x), 0);
      end
      if (c == 2) begin
        check("rel_c2_tick", 32'(a_tick), 1);
        check("rel_c2_x", 32'(a_x), 0);
      end
      if (c == 3) check("rel_c3_x", 32'(a_x), 1);
      if (a_y == 10'd0) begin
        if (a_hs) begin
          hs_clks++;
          if (int'(a_x) < hs_min) hs_min = int'(a_x);
          if (int'(a_x) > hs_max) hs_max = int'(a_x);
        end
        if (!a_vo && vo_fall < 0) vo_fall = int'(a_x);
      end
      if (a_ls) begin
        ls_cnt++; ls_x = int'(a_x); ls_y = int'(a_y); ls_c = c;
      end
      if (a_fs) afs_cnt++;

      if (!b_tick) b_tick_lo++;
      if (b_fs) begin
        b_fs_cnt++;
        if (b_x != 11'd0 || b_y != 10'd0) b_fs_bad++;
        if (b_fs_c1 < 0) b_fs_c1 = c;
        else if (b_fs_c2 < 0) b_fs_c2 = c;
      end
      if (!b_vs) begin
        if (int'(b_y) < b_vs_min) b_vs_min = int'(b_y);
        if (int'(b_y) > b_vs_max) b_vs_max = int'(b_y);
      end
      if (!b_hs) begin
        if (int'(b_x) < b_hs_min) b_hs_min = int'(b_x);
        if (int'(b_x) > b_hs_max) b_hs_max = int'(b_x);
        if (b_y == 10'd0 && c < 392) b_hs_clks0++;
      end
      if (b_vo && (b_y >= 10'd10 || b_x >= 11'd16)) b_vo_bad++;
    end

    check("h_video_on_fall_x", vo_fall, 800);
    check("h_hsync_first_x", hs_min, 856);
    check("h_hsync_last_x", hs_max, 975);
    check("h_hsync_clks", hs_clks, 240);
    check("h_line_start_cnt", ls_cnt, 1);
    check("h_line_start_x", ls_x, 0);
    check("h_line_start_y", ls_y, 1);
    check("h_line_start_clk", ls_c, 2081);
    check("h_no_frame_start", afs_cnt, 0);

    check("b_tick_always_high", b_tick_lo, 0);
    check("b_frame_start_cnt", b_fs_cnt, 5);
    check("b_frame_start_at_origin", b_fs_bad, 0);
    check("b_first_frame_start_clk", b_fs_c1, 392);
    check("b_frame_period", b_fs_c2 - b_fs_c1, 391);
    check("b_vsync_low_first_y", b_vs_min, 12);
    check("b_vsync_low_last_y", b_vs_max, 13);
    check("b_hsync_low_first_x", b_hs_min, 18);
    check("b_hsync_low_last_x", b_hs_max, 20);
    check("b_hsync_low_clks", b_hs_clks0, 3);
    check("b_video_on_outside", b_vo_bad, 0);

    wait_a(708, 1, 4000, found);
    check("align_708_found", 32'(found), 1);
    check("align_708_video_on", 32'(a_vo), 1);
    check("align_708_hsync", 32'(a_hs), 0);
    check("align_708_vsync", 32'(a_vs), 0);
    wait_a(720, 1, 100, found);
    check("align_720_found", 32'(found), 1);
    check("align_720_video_on", 32'(a_vo), 1);

    wait_a(500, 2, 4000, found);
    check("mid_500_found", 32'(found), 1);
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a_ls || a_fs) spur++;
      if (i == 0) begin
        check("mid_rst_x", 32'(a_x), 0);
        check("mid_rst_y", 32'(a_y), 0);
        check("mid_rst_video_on", 32'(a_vo), 0);
        check("mid_rst_tick", 32'(a_tick), 0);
        check("mid_rst_hsync", 32'(a_hs), 0);
      end
    end
    rst_a = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (a_ls || a_fs) spur++;
      if (c == 1) check("mid_rel_video_on", 32'(a_vo), 1);
      if (c == 2) check("mid_rel_x_c2", 32'(a_x), 0);
      if (c == 3) check("mid_rel_x_c3", 32'(a_x), 1);
      if (c == 8) check("mid_rel_y", 32'(a_y), 0);
    end
    check("mid_no_spurious_strobe", spur, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
